// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encodings shared by the 8N1 UART sender and
// receiver. The encodings are plain 2-bit localparams so that legacy blocks
// can compare against them directly.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;   // payload bits per frame, LSB first
    localparam int unsigned OVERSAMPLE = 16;  // enb ticks per bit period
    localparam int unsigned HALF_BIT   = 8;   // ticks from falling edge to start-bit centre

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'b00;
    localparam uart_state_t ST_START = 2'b01;
    localparam uart_state_t ST_DATA  = 2'b10;
    localparam uart_state_t ST_STOP  = 2'b11;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: parallel side of the UART receiver.
//   master (receiver): drives data, rdy, frame_err, overrun, rx_busy; reads rdy_clr
//   slave  (consumer): reads the byte and status; pulses rdy_clr to clear the flags
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;       // last good byte
    logic                 rdy;        // sticky byte-available flag
    logic                 frame_err;  // sticky: stop bit sampled low
    logic                 overrun;    // sticky: good byte landed while rdy was set
    logic                 rx_busy;    // receiver not idle
    logic                 rdy_clr;    // single-cycle clear of rdy/frame_err/overrun

    modport master (
        output data, rdy, frame_err, overrun, rx_busy,
        input  rdy_clr
    );

    modport slave (
        input  data, rdy, frame_err, overrun, rx_busy,
        output rdy_clr
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so an idle line is not mistaken for a start bit.
//   clk, rst_n : clock and async active-low reset
//   async_i    : asynchronous input
//   sync_o     : synchronized output (2 clk latency)
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path, 16x oversampled on the enb tick.
// Validates the start bit at its centre, samples each data bit at its centre
// and the stop bit at its centre, then returns to IDLE immediately so a
// back-to-back start edge is not missed.
//   clk, rst_n : clock and async active-low reset
//   rx         : asynchronous serial line, idle high
//   enb        : single-cycle 16x-baud sample tick
//   bus        : parallel byte, sticky status flags and rdy_clr (master side)
module uart_receiver
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             enb,
    uart_receiver_if.master  bus
);

    localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] START_LAST  = 4'(HALF_BIT - 1);
    localparam logic [2:0] BIT_LAST    = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    uart_state_t          state_q,  state_d;
    logic [3:0]           sample_q, sample_d;
    logic [2:0]           bitpos_q, bitpos_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 rdy_q,    rdy_d;
    logic                 ferr_q,   ferr_d;
    logic                 ovr_q,    ovr_d;

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bitpos_d = bitpos_q;
        shift_d  = shift_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;

        // The clear is applied first so that a frame completing in the same
        // cycle overrides it.
        if (bus.rdy_clr) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (enb) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d  = ST_START;
                        sample_d = 4'd0;
                    end
                end
                ST_START: begin
                    if (rx_s) begin
                        // line went back high before mid-bit: glitch
                        state_d = ST_IDLE;
                    end else if (sample_q == START_LAST) begin
                        state_d  = ST_DATA;
                        sample_d = 4'd0;
                        bitpos_d = 3'd0;
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (sample_q == SAMPLE_LAST) begin
                        shift_d[bitpos_q] = rx_s;
                        sample_d          = 4'd0;
                        if (bitpos_q == BIT_LAST) state_d  = ST_STOP;
                        else                      bitpos_d = bitpos_q + 3'd1;
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (sample_q == SAMPLE_LAST) begin
                        state_d  = ST_IDLE;
                        sample_d = 4'd0;
                        if (rx_s) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                            if (rdy_q && !bus.rdy_clr) ovr_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        sample_d = sample_q + 4'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sample_q <= 4'd0;
            bitpos_q <= 3'd0;
            shift_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bitpos_q <= bitpos_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.rdy       = rdy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives whole 8N1 frames (16 enb ticks per bit, enb every
// 4 clk) and compares the parallel side against a frame-level model of the
// receiver's externally visible flags.
module tb_uart_receiver;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic enb;

    uart_receiver_if bus ();

    uart_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .enb   (enb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // enb: one cycle in four, changed just after the rising edge
    initial begin
        int cyc;
        cyc = 0;
        enb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            enb = (cyc % 4 == 0);
        end
    end

    // monitor: rx_busy around the rising edge of rdy, and busy cycle count
    int   busy_cnt = 0;
    int   rise_cnt = 0;
    logic prev_rdy = 1'b0;
    logic prev_busy = 1'b0;
    logic busy_at_rise = 1'b1;
    logic busy_before_rise = 1'b0;
    always @(negedge clk) begin
        if (bus.rdy && !prev_rdy) begin
            rise_cnt++;
            busy_at_rise     = bus.rx_busy;
            busy_before_rise = prev_busy;
        end
        if (bus.rx_busy) busy_cnt++;
        prev_rdy  = bus.rdy;
        prev_busy = bus.rx_busy;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: what the consumer should see
    logic [7:0] m_data;
    logic       m_rdy, m_ferr, m_ovr;

    task automatic model_reset();
        m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_clr();
        m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    // one complete frame; clr_same = rdy_clr pulsed on the completion cycle
    task automatic model_frame(input logic [7:0] b, input logic stop, input bit clr_same);
        logic had_rdy;
        had_rdy = m_rdy;
        if (clr_same) model_clr();
        if (stop) begin
            if (had_rdy && !clr_same) m_ovr = 1'b1;
            m_rdy  = 1'b1;
            m_data = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"}, bus.data, m_data);
        chk({tag, ".rdy"}, {7'd0, bus.rdy}, {7'd0, m_rdy});
        chk({tag, ".ferr"}, {7'd0, bus.frame_err}, {7'd0, m_ferr});
        chk({tag, ".ovr"}, {7'd0, bus.overrun}, {7'd0, m_ovr});
        chk({tag, ".busy"}, {7'd0, bus.rx_busy}, 8'd0);
    endtask

    // returns 2 ns after a clock edge on which the DUT saw enb=1
    task automatic tick();
        @(posedge clk);
        while (!enb) @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.rdy_clr = 1'b1;
        @(posedge clk); #1 bus.rdy_clr = 1'b0;
        model_clr();
    endtask

    // Frame = start, 8 data LSB first, stop; each bit held 16 ticks.
    // The stop-bit centre falls on the 9th tick of the stop bit; with clr_same
    // rdy_clr is high in exactly the cycle ending on that tick.
    // abort_at < 10 asserts reset at the start of that bit and returns.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit clr_same, input int abort_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        tick();
        for (int j = 0; j < 10; j++) begin
            rx = fr[j];
            if (j == abort_at) begin
                #1 rst_n = 1'b0;
                return;
            end
            for (int t = 1; t <= 16; t++) begin
                if (clr_same && j == 9 && t == 9) begin
                    repeat (3) @(posedge clk);
                    #1 bus.rdy_clr = 1'b1;
                    @(posedge clk);
                    #1 bus.rdy_clr = 1'b0;
                end else begin
                    tick();
                end
            end
        end
        rx = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         mode, c0, r0;

        rst_n = 1'b0;
        rx = 1'b1;
        bus.rdy_clr = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 check_all("reset");
        rst_n = 1'b1;
        repeat (8) tick();

        // basic byte, rx_busy falls on the edge rdy rises
        r0 = rise_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 10);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_all("a5");
        chk("a5.rise", 8'(rise_cnt - r0), 8'd1);
        chk("a5.busy_at_rise", {7'd0, busy_at_rise}, 8'd0);
        chk("a5.busy_before_rise", {7'd0, busy_before_rise}, 8'd1);

        // start glitch: 4 ticks low
        c0 = busy_cnt;
        tick();
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (4) tick();
        check_all("glitch");
        chk("glitch.busy_seen", {7'd0, (busy_cnt > c0)}, 8'd1);

        // framing error
        pulse_clr();
        send_frame(8'h3C, 1'b0, 1'b0, 10);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_all("ferr");
        pulse_clr();
        check_all("ferr_clr");

        // overrun, then the same with rdy_clr on the completion cycle
        send_frame(8'h11, 1'b1, 1'b0, 10);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 10);
        model_frame(8'h22, 1'b1, 1'b0);
        check_all("ovr");
        pulse_clr();
        send_frame(8'h11, 1'b1, 1'b0, 10);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 10);
        model_frame(8'h22, 1'b1, 1'b1);
        check_all("ovr_clr_same");

        // reset during data bit 4
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        model_reset();
        #1 check_all("midrst");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();
        send_frame(8'h5A, 1'b1, 1'b0, 10);
        model_frame(8'h5A, 1'b1, 1'b0);
        check_all("after_rst");

        // sender-style stream, consumer clears between bytes
        pulse_clr();
        send_frame(8'h81, 1'b1, 1'b0, 10);
        model_frame(8'h81, 1'b1, 1'b0);
        check_all("loop81");
        pulse_clr();
        send_frame(8'h7E, 1'b1, 1'b0, 10);
        model_frame(8'h7E, 1'b1, 1'b0);
        check_all("loop7e");
        pulse_clr();

        // random frames, stop bits and clear timing
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 1) pulse_clr();
            send_frame(b, stop, (mode == 2), 10);
            model_frame(b, stop, (mode == 2));
            check_all("rnd");
            repeat ($urandom_range(0, 8)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
